alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 tb/tb_alu_issue_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// One-entry issue register between decode and the ALU, with optional operand forwarding.
// Define ALU_ISSUE_FWD_EN to enable EX/WB forwarding; otherwise register-file values are used directly.
module alu_issue_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [3:0]      alu_ctrl_in,
    input  logic [RA_W-1:0] rd_in,
    input  logic            reg_write_in,
    input  logic            ex_we,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] in1,
    output logic [XLEN-1:0] in2,
    output logic [3:0]      alu_control,
    output logic [RA_W-1:0] rd_out,
    output logic            reg_write_out,
    output logic [15:0]     stall_cnt
);

    logic            out_valid_reg;
    logic [XLEN-1:0] in1_reg;
    logic [XLEN-1:0] in2_reg;
    logic [3:0]      alu_control_reg;
    logic [RA_W-1:0] rd_out_reg;
    logic            reg_write_out_reg;
    logic [15:0]     stall_cnt_reg;

    logic            capture;
    logic            handoff;
    logic            stalled;
    logic [XLEN-1:0] op2_next;

    // Index 0 is rs1, index 1 is rs2.
    logic [1:0][RA_W-1:0] src_addr;
    logic [1:0][XLEN-1:0] src_data;
    logic [1:0][XLEN-1:0] fwd_data;

    assign src_addr = {rs2_addr, rs1_addr};
    assign src_data = {rs2_data, rs1_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ALU_ISSUE_FWD_EN
            logic ex_hit;
            logic wb_hit;
            // EX is younger than WB, so it wins; x0 is hardwired and never forwarded.
            assign ex_hit = ex_we && (ex_rd == src_addr[gi]) && (ex_rd != '0);
            assign wb_hit = wb_we && (wb_rd == src_addr[gi]) && (wb_rd != '0);
            assign fwd_data[gi] = ex_hit ? ex_data : (wb_hit ? wb_data : src_data[gi]);
`else
            assign fwd_data[gi] = src_data[gi];
`endif
        end
    endgenerate

`ifndef ALU_ISSUE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_we, ex_rd, ex_data, wb_we, wb_rd, wb_data, src_addr};
`endif

    assign in_ready = !out_valid_reg || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign handoff  = out_valid_reg && out_ready;
    assign stalled  = out_valid_reg && !out_ready;
    assign op2_next = use_imm ? imm : fwd_data[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            stall_cnt_reg <= 16'd0;
        end else begin
            // Flush squashes the held entry and any same-cycle input.
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (capture) begin
                out_valid_reg <= 1'b1;
            end else if (handoff) begin
                out_valid_reg <= 1'b0;
            end
            if (stalled && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_reg           <= '0;
            in2_reg           <= '0;
            alu_control_reg   <= 4'b0000;
            rd_out_reg        <= '0;
            reg_write_out_reg <= 1'b0;
        end else if (capture) begin
            in1_reg           <= fwd_data[0];
            in2_reg           <= op2_next;
            alu_control_reg   <= alu_ctrl_in;
            rd_out_reg        <= rd_in;
            reg_write_out_reg <= reg_write_in;
        end
    end

    assign out_valid     = out_valid_reg;
    assign in1           = in1_reg;
    assign in2           = in2_reg;
    assign alu_control   = alu_control_reg;
    assign rd_out        = rd_out_reg;
    assign reg_write_out = reg_write_out_reg;
    assign stall_cnt     = stall_cnt_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage; forwarding expectations follow ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [3:0]      ctrl;
        logic [RA_W-1:0] rd;
        logic            we;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [3:0]      alu_ctrl_in;
    logic [RA_W-1:0] rd_in;
    logic            reg_write_in;
    logic            ex_we;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            wb_we;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [3:0]      alu_control;
    logic [RA_W-1:0] rd_out;
    logic            reg_write_out;
    logic [15:0]     stall_cnt;

    alu_issue_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .use_imm(use_imm),
        .alu_ctrl_in(alu_ctrl_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .in1(in1), .in2(in2), .alu_control(alu_control),
        .rd_out(rd_out), .reg_write_out(reg_write_out),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          txns     = 0;
    entry_t      sb[$];
    entry_t      exp_regs;
    logic        exp_valid;
    logic [15:0] exp_stall;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%h required=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
`ifdef ALU_ISSUE_FWD_EN
        if (ex_we && ex_rd == a && ex_rd != '0) return ex_data;
        if (wb_we && wb_rd == a && wb_rd != '0) return wb_data;
`endif
        return d;
    endfunction

    function automatic entry_t model_entry();
        entry_t e;
        e.in1  = fwd(rs1_addr, rs1_data);
        e.in2  = use_imm ? imm : fwd(rs2_addr, rs2_data);
        e.ctrl = alu_ctrl_in;
        e.rd   = rd_in;
        e.we   = reg_write_in;
        return e;
    endfunction

    task automatic set_op(input logic [RA_W-1:0] a1, input logic [RA_W-1:0] a2,
                          input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                          input logic ui, input logic [XLEN-1:0] im,
                          input logic [3:0] c, input logic [RA_W-1:0] rd, input logic we);
        in_valid = 1'b1; rs1_addr = a1; rs2_addr = a2; rs1_data = d1; rs2_data = d2;
        use_imm = ui; imm = im; alu_ctrl_in = c; rd_in = rd; reg_write_in = we;
    endtask

    // Called at a falling edge with this cycle's inputs driven; checks, advances the model, clocks once.
    task automatic tick();
        entry_t e;
        logic   hand;
        logic   cap;
        #1;
        check_val("in_ready", 64'(in_ready), 64'(!exp_valid || out_ready));
        check_val("out_valid", 64'(out_valid), 64'(exp_valid));
        check_val("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        check_val("hold_in1", in1, exp_regs.in1);
        check_val("hold_in2", in2, exp_regs.in2);
        check_val("hold_ctrl", 64'(alu_control), 64'(exp_regs.ctrl));
        check_val("hold_rd", 64'(rd_out), 64'(exp_regs.rd));
        check_val("hold_we", 64'(reg_write_out), 64'(exp_regs.we));
        hand = exp_valid && out_ready;
        cap  = in_valid && (!exp_valid || out_ready) && !flush;
        if (hand) begin
            check_val("sb_depth", 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val("txn_in1", in1, e.in1);
                check_val("txn_in2", in2, e.in2);
                check_val("txn_ctrl", 64'(alu_control), 64'(e.ctrl));
                check_val("txn_rd", 64'(rd_out), 64'(e.rd));
                check_val("txn_we", 64'(reg_write_out), 64'(e.we));
                txns++;
                $display("txn %0d in1=%h in2=%h ctrl=%h rd=%0d we=%0d",
                         txns, in1, in2, alu_control, rd_out, reg_write_out);
            end
        end
        if (exp_valid && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        if (flush) begin
            sb.delete();
            exp_valid = 1'b0;
        end else if (cap) begin
            e = model_entry();
            sb.push_back(e);
            exp_regs  = e;
            exp_valid = 1'b1;
        end else if (hand) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0] s0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0;
        alu_ctrl_in = '0; rd_in = '0; reg_write_in = 1'b0;
        ex_we = 1'b0; ex_rd = '0; ex_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        exp_valid = 1'b0; exp_regs = '0; exp_stall = 16'd0;

        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_in1", in1, 64'd0);
        check_val("rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;

        // Basic issue
        set_op(5'd1, 5'd2, 64'd5, 64'd7, 1'b0, 64'd0, 4'b0010, 5'd9, 1'b1);
        tick();
        check_val("basic_valid", 64'(out_valid), 64'd1);
        check_val("basic_in1", in1, 64'd5);
        check_val("basic_in2", in2, 64'd7);
        check_val("basic_ctrl", 64'(alu_control), 64'b0010);

        // Forwarding priority: EX, then WB, then x0 never forwarded
        ex_we = 1'b1; ex_rd = 5'd3; ex_data = 64'hAA;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 64'hBB;
        set_op(5'd3, 5'd3, 64'h11, 64'h22, 1'b0, 64'd0, 4'h1, 5'd4, 1'b1);
        tick();
`ifdef ALU_ISSUE_FWD_EN
        check_val("fwd_ex_in1", in1, 64'hAA);
`else
        check_val("nofwd_in1", in1, 64'h11);
`endif
        ex_we = 1'b0;
        tick();
`ifdef ALU_ISSUE_FWD_EN
        check_val("fwd_wb_in1", in1, 64'hBB);
`else
        check_val("nofwd_in1_b", in1, 64'h11);
`endif
        ex_we = 1'b1; ex_rd = 5'd0; wb_rd = 5'd0;
        set_op(5'd0, 5'd0, 64'h33, 64'h44, 1'b0, 64'd0, 4'h3, 5'd5, 1'b0);
        tick();
        check_val("fwd_x0_in1", in1, 64'h33);
        ex_we = 1'b0; wb_we = 1'b0;

        // Immediate operand
        set_op(5'd6, 5'd7, 64'h55, 64'h66, 1'b1, -64'sd4, 4'h4, 5'd6, 1'b1);
        tick();
        check_val("imm_in2", in2, 64'hFFFF_FFFF_FFFF_FFFC);

        // Backpressure: held entry, new input refused, stall counter advances
        set_op(5'd8, 5'd9, 64'h100, 64'h200, 1'b0, 64'd0, 4'h5, 5'd10, 1'b1);
        tick();
        out_ready = 1'b0;
        s0 = stall_cnt;
        set_op(5'd11, 5'd12, 64'h300, 64'h400, 1'b0, 64'd0, 4'h6, 5'd11, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check_val("bp_stall_delta", 64'(stall_cnt - s0), 64'd4);
        check_val("bp_in1_held", in1, 64'h100);
        out_ready = 1'b1;
        tick();
        check_val("b2b_in1", in1, 64'h300);

        // Flush while holding, with a same-cycle input
        out_ready = 1'b0;
        set_op(5'd13, 5'd14, 64'hDEAD, 64'hBEEF, 1'b0, 64'd0, 4'h7, 5'd12, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_val("flush_in1_kept", in1, 64'h300);
        // Flush while empty, with a same-cycle input
        out_ready = 1'b1;
        set_op(5'd15, 5'd16, 64'hF00D, 64'hCAFE, 1'b0, 64'd0, 4'h8, 5'd13, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_val("flush_empty_valid", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_op(RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7)),
                   {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 4'($urandom), RA_W'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            ex_we = 1'($urandom); ex_rd = RA_W'($urandom_range(0, 7)); ex_data = {$urandom, $urandom};
            wb_we = 1'($urandom); wb_rd = RA_W'($urandom_range(0, 7)); wb_data = {$urandom, $urandom};
            tick();
        end
        flush = 1'b0; ex_we = 1'b0; wb_we = 1'b0; out_ready = 1'b1;

        // Stall counter saturation
        set_op(5'd1, 5'd1, 64'h77, 64'h88, 1'b0, 64'd0, 4'h9, 5'd1, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 65540; i++) tick();
        check_val("stall_saturated", 64'(stall_cnt), 64'hFFFF);

        // Asynchronous reset mid-stall, between clock edges
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_stall", 64'(stall_cnt), 64'd0);
        check_val("arst_in1", in1, 64'd0);
        check_val("arst_in2", in2, 64'd0);
        check_val("arst_ctrl", 64'(alu_control), 64'd0);
        check_val("arst_rd", 64'(rd_out), 64'd0);
        check_val("arst_we", 64'(reg_write_out), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);
        sb.delete(); exp_valid = 1'b0; exp_regs = '0; exp_stall = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        set_op(5'd2, 5'd3, 64'h1234, 64'h5678, 1'b0, 64'd0, 4'hA, 5'd7, 1'b1);
        tick();
        check_val("post_rst_in1", in1, 64'h1234);
        in_valid = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
